add_accumulator: RTL
====================

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 SHALL have parameter ACC_NIBBLES, default 2; the accumulator is 4*ACC_NIBBLES bits wide (legal range 1..8).
REQ-002 SHALL have one clock and asynchronous active-high reset, named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand offered this cycle.
REQ-006 in_data  input  4  unsigned operand, zero-extended to accumulator width.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 clr  input  1  synchronous clear request for the accumulator and overflow flag.
REQ-009 acc_out  output  4*ACC_NIBBLES  current accumulator value.
REQ-010 acc_valid  output  1  high when acc_out is stable, i.e. state IDLE.
REQ-011 done  output  1  one-cycle pulse when an accumulation completes.
REQ-012 ovf  output  1  sticky overflow flag: a carry came out of the top nibble.

Function
REQ-013 SHALL use FSM states IDLE, ADD and DONE, with a nibble index idx (0..ACC_NIBBLES-1) and a 1-bit carry register.
REQ-014 in_ready SHALL be (state==IDLE) && !clr && !rst; a transfer occurs on a rising edge where in_valid && in_ready.
REQ-015 On transfer, SHALL latch in_data as operand, set idx=0, clear carry and enter ADD.
REQ-016 Each ADD cycle SHALL perform a single 4-bit add: {carry, acc[idx nibble]} <= acc[idx nibble] + opnd[idx nibble] + carry; then idx++.
REQ-017 The operand nibbles above nibble 0 SHALL be zero.
REQ-018 The carry SHALL ripple between consecutive ADD cycles, so a nibble carry-out propagates into the next nibble.
REQ-019 After the ADD cycle with idx==ACC_NIBBLES-1, the FSM SHALL enter DONE.
REQ-020 In DONE, the block SHALL drive done=1 for exactly one cycle, set ovf |= carry, and return to IDLE.
REQ-021 Latency: transfer at edge k gives done high during the cycle after edge k+ACC_NIBBLES; in_ready is high again one cycle later.
REQ-022 Maximum throughput SHALL be one operand per ACC_NIBBLES+2 cycles.
REQ-023 Accumulator arithmetic SHALL wrap modulo 2^(4*ACC_NIBBLES).
REQ-024 ovf SHALL stay set until clr or rst.
REQ-025 acc_out MAY show partially updated nibbles during ADD; acc_valid SHALL be 0 in ADD and DONE.
REQ-026 clr SHALL be honoured only in IDLE, where it zeroes acc and ovf at the next edge.
REQ-027 clr asserted with in_valid in IDLE SHALL win: no operand is accepted.
REQ-028 clr asserted in ADD or DONE SHALL be ignored and not queued.
REQ-029 in_data and in_valid SHALL be ignored while in_ready is 0; in_valid held high SHALL cause only one transfer per transaction.

Reset
REQ-030 rst SHALL immediately force: state=IDLE, acc_out=0, ovf=0, done=0, idx=0, carry=0, acc_valid=1, and in_ready=0 while rst is high.
REQ-031 rst asserted mid-ADD or in DONE SHALL abort the transaction with no done pulse; the first transfer after release starts from acc=0.

Verification (ACC_NIBBLES=2)
REQ-032 Reset, then add 0x6 and then 0xC -> acc_out=0x06 and then 0x12, ovf=0, each done pulse 3 cycles after its transfer.
REQ-033 Drive acc=0x0F, then add 0x1 -> nibble carry propagates, acc_out=0x10, ovf=0.
REQ-034 Drive acc=0xFE, then add 0x3 -> acc_out=0x01, ovf=1; a following add of 0x1 gives acc_out=0x02 with ovf still 1; clr then gives acc_out=0x00, ovf=0.
REQ-035 Assert clr and in_valid together in IDLE with acc=0x12 -> in_ready=0 that cycle, acc_out=0x00, no transfer, no done.
REQ-036 Hold in_valid=1 with data 0x1 for 12 cycles from acc=0 -> exactly 3 transfers (one every 4 cycles), acc_out=0x03, 3 done pulses.
REQ-037 Assert rst one cycle after a transfer of 0x5 onto acc=0x30 -> acc_out=0x00 immediately, no done pulse, IDLE after release.

Source files
------------

// File: rtl/add_accumulator_if.sv
// Operand/result bundle for add_accumulator: master offers 4-bit operands and clear,
// slave returns ready, accumulator value and status.
interface add_accumulator_if #(
  parameter int ACC_NIBBLES = 2
);
  logic                     in_valid;
  logic [3:0]               in_data;
  logic                     in_ready;
  logic                     clr;
  logic [4*ACC_NIBBLES-1:0] acc_out;
  logic                     acc_valid;
  logic                     done;
  logic                     ovf;

  modport master (
    output in_valid, in_data, clr,
    input  in_ready, acc_out, acc_valid, done, ovf
  );

  modport slave (
    input  in_valid, in_data, clr,
    output in_ready, acc_out, acc_valid, done, ovf
  );
endinterface

// File: rtl/add_accumulator.sv
// Nibble-serial accumulator: one 4-bit add per cycle, done pulses ACC_NIBBLES+1 cycles after a transfer.
// in_ready is low outside IDLE (and during clr/rst); offered operands simply wait.
module add_accumulator #(
  parameter int ACC_NIBBLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  add_accumulator_if.slave  bus
);
  localparam int W  = 4 * ACC_NIBBLES;
  localparam int IW = (ACC_NIBBLES > 1) ? $clog2(ACC_NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(ACC_NIBBLES - 1);

  logic [1:0]    state;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_nxt;
  logic [3:0]    opnd;
  logic [IW-1:0] idx;
  logic          carry;
  logic          ovf;
  logic          rdy;
  logic [3:0]    cur_nib;
  logic [3:0]    opnd_nib;
  logic [4:0]    sum;

  assign rdy           = (state == IDLE) && !bus.clr && !rst;
  assign bus.in_ready  = rdy;
  assign bus.acc_out   = acc;
  assign bus.acc_valid = (state == IDLE);
  assign bus.done      = (state == DONE);
  assign bus.ovf       = ovf;

  // Only nibble 0 of the operand is non-zero; higher nibbles just absorb the carry.
  always_comb begin
    cur_nib  = acc[{idx, 2'b00} +: 4];
    opnd_nib = (idx == '0) ? opnd : 4'd0;
    sum      = {1'b0, cur_nib} + {1'b0, opnd_nib} + {4'd0, carry};
    acc_nxt  = acc;
    acc_nxt[{idx, 2'b00} +: 4] = sum[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      opnd  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr) begin
            acc <= '0;
            ovf <= 1'b0;
          end else if (bus.in_valid && rdy) begin
            opnd  <= bus.in_data;
            idx   <= '0;
            carry <= 1'b0;
            state <= ADD;
          end
        end
        ADD: begin
          acc   <= acc_nxt;
          carry <= sum[4];
          if (idx == LAST) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // carry here is the carry-out of the top nibble
          ovf   <= ovf | carry;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
